// File: rtl/programmable_clock_divider.sv
// Multi-channel runtime-programmable clock divider.
// Each channel emits a 50% square wave plus a rise-aligned tick strobe.
module programmable_clock_divider #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(32'h2FAF080),
  parameter int unsigned SEL_W =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLOCK_50MHZ,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] ENABLE,
  input  logic                SYNC,
  input  logic                LOAD,
  input  logic [SEL_W-1:0]    LOAD_SEL,
  input  logic [WIDTH-1:0]    LOAD_DIV,
  output logic [CHANNELS-1:0] NEW_CLOCK,
  output logic [CHANNELS-1:0] TICK,
  output logic [CHANNELS-1:0] PENDING
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] pend_div;
    logic             pending;
    logic             wave;
    logic             tick;
    logic             hit;
    logic             terminal;

    // Out-of-range selects never match any channel index.
    assign hit = LOAD && (LOAD_SEL == SEL_W'(i));
    assign terminal = (counter == active_div);

    always_ff @(posedge CLOCK_50MHZ) begin
      if (RESET) begin
        counter    <= '0;
        active_div <= DEFAULT_DIV;
        pend_div   <= '0;
        pending    <= 1'b0;
        wave       <= 1'b0;
        tick       <= 1'b0;
      end else if (SYNC || !ENABLE[i]) begin
        counter <= '0;
        wave    <= 1'b0;
        tick    <= 1'b0;
        pending <= 1'b0;
        if (hit) begin
          active_div <= LOAD_DIV;
        end else if (pending) begin
          active_div <= pend_div;
        end
      end else if (terminal) begin
        counter <= '0;
        wave    <= ~wave;
        tick    <= ~wave;
        pending <= 1'b0;
        if (hit) begin
          active_div <= LOAD_DIV;
        end else if (pending) begin
          active_div <= pend_div;
        end
      end else begin
        counter <= counter + WIDTH'(1);
        tick    <= 1'b0;
        // Defer to the next terminal so the current half-period is kept.
        if (hit) begin
          pend_div <= LOAD_DIV;
          pending  <= 1'b1;
        end
      end
    end

    assign NEW_CLOCK[i] = wave;
    assign TICK[i]      = tick;
    assign PENDING[i]   = pending;
  end

endmodule
